// File: rtl/led_pkg.sv
// Shared LED definitions: debounce FSM encoding, default PWM width and matrix geometry.
// Used by the button/PWM controller and by the matrix colour stage.
package led_pkg;

   typedef enum logic [1:0] {
      DB_REL        = 2'd0,
      DB_WAIT_PRESS = 2'd1,
      DB_PRESSED    = 2'd2,
      DB_WAIT_REL   = 2'd3
   } db_state_t;

   localparam int LED_PWM_BITS = 8;
   localparam int MATRIX_COLS  = 25;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, four-state debounce FSM and registered one-cycle press pulse
// for one raw active-low button. The FSM state is exported for observation.
module btn_debounce
   import led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      btn_n,
   output logic      press,
   output db_state_t state
);

   localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2;
   db_state_t     state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          press_nxt;

   // Synchronizer resets to the released level so a held button is seen as a fresh press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DB_REL;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         press <= press_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      press_nxt = 1'b0;
      case (state)
         DB_REL: begin
            if (!sync2) state_nxt = DB_WAIT_PRESS;
         end
         DB_WAIT_PRESS: begin
            if (sync2) begin
               state_nxt = DB_REL;
            end else if (cnt == LAST) begin
               state_nxt = DB_PRESSED;
               press_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DB_PRESSED: begin
            if (sync2) state_nxt = DB_WAIT_REL;
         end
         DB_WAIT_REL: begin
            if (!sync2) begin
               state_nxt = DB_PRESSED;
            end else if (cnt == LAST) begin
               state_nxt = DB_REL;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = DB_REL;
      endcase
   end

endmodule

// File: rtl/button_pwm_ctrl.sv
// Button-driven LED PWM: debounced colour/brightness buttons, free-running PWM and duty stepping.
// Define BUTTON_PWM_BREATH_EN for the automatic triangle (breathing) ramp.
module button_pwm_ctrl
   import led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PWM_BITS        = LED_PWM_BITS,
   parameter int DUTY_STEP       = 16,
   parameter int BREATH_DIV      = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                btn_n,
   input  logic                btn_dim_n,
   output logic                f_edge,
   output logic                pwm_out,
   output logic                up_down,
   output logic [PWM_BITS-1:0] duty,
   output db_state_t           btn_state,
   output db_state_t           dim_state
);

   localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
   localparam logic [PWM_BITS-1:0] DUTY_RST = {1'b1, {(PWM_BITS-1){1'b0}}};
   localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS+1)'(DUTY_STEP);
   localparam logic [PWM_BITS:0]   MAX_EXT  = {1'b0, CNT_MAX};

   if (DEBOUNCE_CYCLES < 1 || BREATH_DIV < 1 || PWM_BITS < 2 ||
       DUTY_STEP < 1 || DUTY_STEP >= 2**PWM_BITS) begin : g_bad_param
      $error("button_pwm_ctrl: invalid parameter set");
   end

   logic                dim_press;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                pend, step_req, apply, dir_toggle;
   logic [PWM_BITS:0]   up_sum;
   logic [PWM_BITS-1:0] duty_nxt;
   logic                dir_nxt;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_n),
      .press (f_edge),
      .state (btn_state)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dim (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_dim_n),
      .press (dim_press),
      .state (dim_state)
   );

`ifdef BUTTON_PWM_BREATH_EN
   localparam int          PW      = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(BREATH_DIV - 1);
   logic [PW-1:0] pre_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                pre_cnt <= '0;
      else if (pre_cnt == PRE_LAST) pre_cnt <= '0;
      else                       pre_cnt <= pre_cnt + PW'(1);
   end

   assign step_req   = (pre_cnt == PRE_LAST);
   assign dir_toggle = dim_press;
`else
   assign step_req   = dim_press;
   assign dir_toggle = 1'b0;
`endif

   // Steps land only at the end of a PWM period so a period never sees two duty values.
   assign apply = pend && (pwm_cnt == CNT_MAX);

   always_comb begin
      up_sum   = {1'b0, duty} + STEP_EXT;
      duty_nxt = duty;
      dir_nxt  = up_down;
      if (up_down) begin
         if (up_sum >= MAX_EXT) begin
            duty_nxt = CNT_MAX;
            dir_nxt  = 1'b0;
         end else begin
            duty_nxt = up_sum[PWM_BITS-1:0];
         end
      end else begin
         if ({1'b0, duty} <= STEP_EXT) begin
            duty_nxt = '0;
            dir_nxt  = 1'b1;
         end else begin
            duty_nxt = duty - STEP_EXT[PWM_BITS-1:0];
         end
      end
   end

   // A clamp-driven direction change wins over a manual toggle landing on the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         pwm_out <= 1'b1;
         pend    <= 1'b0;
         duty    <= DUTY_RST;
         up_down <= 1'b1;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         pwm_out <= (pwm_cnt >= duty);
         pend    <= (pwm_cnt == CNT_MAX) ? step_req : (pend | step_req);
         if (apply) begin
            duty    <= duty_nxt;
            up_down <= dir_nxt;
         end else if (dir_toggle) begin
            up_down <= ~up_down;
         end
      end
   end

endmodule

// File: doc/button_pwm_ctrl.md
BUTTON_PWM_CTRL -- requirements
Module: button_pwm_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles needed to accept a button level.
REQ-002 SHALL have parameter PWM_BITS, default 8, meaning the width of the PWM counter and duty.
REQ-003 SHALL have parameter DUTY_STEP, default 16, meaning the duty increment or decrement per step.
REQ-004 SHALL have parameter BREATH_DIV, default 50000, meaning clock cycles per automatic duty step (used only with BREATH_EN).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port btn_n, input, 1 bit: raw, asynchronous, active-low colour-mode button.
REQ-008 SHALL have port btn_dim_n, input, 1 bit: raw, asynchronous, active-low brightness button.
REQ-009 SHALL have port f_edge, output, 1 bit: one-cycle pulse on an accepted btn_n press.
REQ-010 SHALL have port pwm_out, output, 1 bit: blanking signal; 1 = LEDs off, 0 = LEDs on.
REQ-011 SHALL have port up_down, output, 1 bit: duty direction; 1 = rising, 0 = falling.
REQ-012 SHALL have port duty, output, PWM_BITS bits: current duty value.

Function
REQ-013 SHALL pass each button through a two-flop synchronizer before any other logic.
REQ-014 SHALL debounce each button with a 4-state FSM: REL, WAIT_PRESS, PRESSED, WAIT_REL.
- REL -> WAIT_PRESS when the synchronized level is 0.
- WAIT_PRESS -> PRESSED after DEBOUNCE_CYCLES consecutive 0 samples; any 1 sample -> REL and the counter clears.
- PRESSED -> WAIT_REL when the level is 1.
- WAIT_REL -> REL after DEBOUNCE_CYCLES consecutive 1 samples; any 0 sample -> PRESSED.
REQ-015 SHALL assert the press pulse for exactly one cycle on the WAIT_PRESS -> PRESSED transition, registered; for btn_n this pulse is f_edge.
REQ-016 SHALL assert f_edge exactly 2 + DEBOUNCE_CYCLES + 1 rising edges after the first edge that samples btn_n low, provided btn_n stays low.
REQ-017 SHALL never produce a second press pulse until the WAIT_REL -> REL transition has completed.
REQ-018 SHALL run a free-running PWM counter 0 .. 2^PWM_BITS-1 that wraps to 0.
REQ-019 SHALL register pwm_out = (counter >= duty).
- duty = 0: permanently blank.
- duty = max: on for max / 2^PWM_BITS of the period.
REQ-020 SHALL hold a duty step request in a single pending flag; repeated requests before it is applied SHALL NOT accumulate.
REQ-021 SHALL apply a pending step only on the cycle where the counter equals its maximum, so duty is glitch-free within a period.
REQ-022 SHALL step duty by DUTY_STEP in the up_down direction and saturate at 0 and 2^PWM_BITS-1.
- Reaching the max bound SHALL set up_down to 0.
- Reaching the 0 bound SHALL set up_down to 1.
- Direction changes in the same cycle as the clamp.
REQ-023 SHALL favour the step when a pending step and a new request occur in the same cycle: the step is applied and the flag stays set only if a fresh request arrives in that cycle.

Reset
REQ-024 SHALL, on rst_n low, immediately and asynchronously force these values:
- f_edge = 0, pwm_out = 1, up_down = 1
- duty = 2^(PWM_BITS-1)
- PWM counter = 0, pending flag = 0
- both FSMs = REL, debounce counters = 0
REQ-025 SHALL, if reset asserts mid-debounce or mid-press, emit no f_edge on release of reset even when the buttons are held; a held button is accepted only after the full REL -> PRESSED sequence.

Configuration
REQ-026 SHALL use macro BUTTON_PWM_BREATH_EN to select the brightness mode.
- Defined: a BREATH_DIV prescaler raises a step request every BREATH_DIV cycles, giving a triangle ramp; a btn_dim_n press toggles up_down.
- Undefined: only btn_dim_n presses raise step requests, and the prescaler is absent.

Structure
REQ-027 SHALL place the following in shared package led_pkg, also used by the matrix colour stage:
- the debounce FSM state encoding;
- the default PWM_BITS;
- the matrix column count 25.
REQ-028 SHALL implement sync plus debounce plus pulse as sub-module btn_debounce, instantiated twice.

Verification
All scenarios use DEBOUNCE_CYCLES=4, PWM_BITS=4, DUTY_STEP=4, BREATH_DIV=8.
REQ-029 SHALL cover: btn_n low held for 20 cycles -> exactly one f_edge pulse, on edge 7; release and re-press -> a second pulse.
REQ-030 SHALL cover: btn_n toggling every 2 cycles for 30 cycles -> no f_edge.
REQ-031 SHALL cover: duty=8, no requests -> pwm_out 0 for counts 0-7 and 1 for counts 8-15, repeating every 16 cycles.
REQ-032 SHALL cover: with the macro undefined, three dim presses from duty=8 -> duty 12, 15 (clamp, up_down=0), then 11, each change at a counter wrap.
REQ-033 SHALL cover: rst_n pulsed low mid-WAIT_PRESS with btn_n held -> outputs take their reset values asynchronously, and f_edge appears only 7 edges after rst_n rises.
REQ-034 SHALL cover: with the macro defined and no presses -> duty rises by 4 per application to 15, then falls to 0, then rises again.
